// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared BTB entry type, PC constants and counter helper
// Purpose: common types for the next-PC predictor slice.
//   btb_entry_t    : one BTB entry (valid, tag, target, 2-bit counter)
//   PC_INC         : sequential PC step
//   CTR_MAX        : saturation ceiling of the direction counter
//   sat_ctr_update : 2-bit saturating increment/decrement
package cpu_pkg;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [1:0]  CTR_MAX = 2'b11;

  // Tag is held zero-extended to 32 bits so the type does not depend on
  // the table depth; the unused upper bits simply stay 0.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr,
                                                input logic       taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00)   ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// rtl/next_pc_predictor_if.sv - execute-stage branch resolution bus
// Purpose: carries one resolved control-flow instruction from execute.
//   ex_valid       : a resolved branch/jump is present this cycle
//   ex_pc          : PC of that instruction
//   ex_taken       : actual direction (1 for jumps)
//   ex_target      : actual target
//   ex_pred_taken  : direction predicted at fetch
//   ex_pred_target : target predicted at fetch
// master = execute stage (drives), slave = predictor (receives).
interface next_pc_predictor_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  modport master (
    output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target
  );
  modport slave (
    input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target
  );
endinterface

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped BTB storage with async clear
// Purpose: holds ENTRIES btb_entry_t records.
//   i_clk, i_rst           : clock, async active-low clear of every entry
//   i_rd_idx, i_rd_tag     : combinational lookup port
//   o_rd_hit               : valid entry with matching tag
//   o_rd_taken             : hit and counter in a taken state
//   o_rd_target            : stored target on hit, else 0
//   i_wr_en/idx/tag        : resolved-branch update port (synchronous)
//   i_wr_taken, i_wr_target: resolved outcome
module btb_table
  import cpu_pkg::*;
#(
  parameter int         ENTRIES  = 32,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter int         TAG_W    = 30 - IDX_W,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  input  logic [TAG_W-1:0]  i_rd_tag,
  output logic              o_rd_hit,
  output logic              o_rd_taken,
  output logic [31:0]       o_rd_target,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic              i_wr_taken,
  input  logic [31:0]       i_wr_target
);

  btb_entry_t r_mem [ENTRIES];

  btb_entry_t w_rd_entry;
  btb_entry_t w_wr_entry;
  logic       w_wr_hit;

  // Lookup reads the registered array, so a same-cycle update is only
  // visible from the following cycle.
  assign w_rd_entry  = r_mem[i_rd_idx];
  assign o_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == 32'(i_rd_tag));
  assign o_rd_taken  = o_rd_hit && w_rd_entry.ctr[1];
  assign o_rd_target = o_rd_hit ? w_rd_entry.target : 32'd0;

  assign w_wr_entry  = r_mem[i_wr_idx];
  assign w_wr_hit    = w_wr_entry.valid && (w_wr_entry.tag == 32'(i_wr_tag));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      if (w_wr_hit) begin
        r_mem[i_wr_idx].ctr <= sat_ctr_update(w_wr_entry.ctr, i_wr_taken);
        if (i_wr_taken) r_mem[i_wr_idx].target <= i_wr_target;
      end else if (i_wr_taken) begin
        // Direct-mapped: a taken miss evicts whatever occupies the slot.
        r_mem[i_wr_idx] <= '{valid: 1'b1, tag: 32'(i_wr_tag),
                             target: i_wr_target, ctr: CNT_INIT};
      end
    end
  end

endmodule

// File: rtl/next_pc_predictor.sv
// rtl/next_pc_predictor.sv - BTB-based next-PC generator with redirect
// Purpose: chooses the next PC, detects mispredictions and flushes.
//   i_clk, i_rst   : clock, async active-low reset
//   i_pc           : current PC from the PC register
//   i_stall        : fetch stall
//   i_ex           : execute-stage resolution bus (slave)
//   o_pc_next      : next PC value
//   o_pc_wren      : PC register write-enable
//   o_pred_taken   : fetch-time direction prediction for i_pc
//   o_pred_target  : fetch-time target prediction for i_pc
//   o_flush        : kill fetch and decode
//   o_mispred_cnt  : running misprediction count
module next_pc_predictor
  import cpu_pkg::*;
#(
  parameter int         ENTRIES  = 32,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [31:0]         i_pc,
  input  logic                i_stall,
  next_pc_predictor_if.slave  i_ex,
  output logic [31:0]         o_pc_next,
  output logic                o_pc_wren,
  output logic                o_pred_taken,
  output logic [31:0]         o_pred_target,
  output logic                o_flush,
  output logic [31:0]         o_mispred_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic        w_mispred;
  logic [31:0] w_pc_seq;
  logic [31:0] w_ex_seq;
  logic [31:0] r_mispred_cnt;

  btb_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .CNT_INIT (CNT_INIT)
  ) u_btb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (i_pc[IDX_W+1:2]),
    .i_rd_tag    (i_pc[31:IDX_W+2]),
    .o_rd_hit    (),
    .o_rd_taken  (o_pred_taken),
    .o_rd_target (o_pred_target),
    .i_wr_en     (i_ex.ex_valid),
    .i_wr_idx    (i_ex.ex_pc[IDX_W+1:2]),
    .i_wr_tag    (i_ex.ex_pc[31:IDX_W+2]),
    .i_wr_taken  (i_ex.ex_taken),
    .i_wr_target (i_ex.ex_target)
  );

  assign w_pc_seq = i_pc + PC_INC;
  assign w_ex_seq = i_ex.ex_pc + PC_INC;

  // A correct direction with a wrong target still counts when both taken.
  assign w_mispred = i_ex.ex_valid &&
                     ((i_ex.ex_taken != i_ex.ex_pred_taken) ||
                      (i_ex.ex_taken && i_ex.ex_pred_taken &&
                       (i_ex.ex_target != i_ex.ex_pred_target)));

  // Redirect beats stall: the correction must land even while fetch is held.
  always_comb begin
    o_pc_next = w_pc_seq;
    o_pc_wren = 1'b1;
    o_flush   = 1'b0;
    if (w_mispred) begin
      o_pc_next = i_ex.ex_taken ? i_ex.ex_target : w_ex_seq;
      o_flush   = 1'b1;
    end else if (i_stall) begin
      o_pc_wren = 1'b0;
    end else if (o_pred_taken) begin
      o_pc_next = o_pred_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         r_mispred_cnt <= 32'd0;
    else if (w_mispred) r_mispred_cnt <= r_mispred_cnt + 32'd1;
  end

  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_next_pc_predictor.sv
// tb/tb_next_pc_predictor.sv - scoreboard bench for next_pc_predictor
module tb_next_pc_predictor;

  localparam int ENTRIES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] pc_next;
  logic        pc_wren;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic [31:0] mispred_cnt;

  next_pc_predictor_if ex_if ();

  next_pc_predictor #(.ENTRIES(ENTRIES)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_pc          (pc),
    .i_stall       (stall),
    .i_ex          (ex_if),
    .o_pc_next     (pc_next),
    .o_pc_wren     (pc_wren),
    .o_pred_taken  (pred_taken),
    .o_pred_target (pred_target),
    .o_flush       (flush),
    .o_mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_next;
    logic        wren;
    logic        pt;
    logic [31:0] ptgt;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the BTB as plain arrays indexed by word address.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_cnt;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic bit m_pred(input logic [31:0] a);
    return m_hit(a) && (m_ctr[idx_of(a)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] a);
    return m_hit(a) ? m_tgt[idx_of(a)] : 32'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pc=%h actual=%h required=%h", name, pc, act, exp);
    end
  endtask

  // One cycle of stimulus: drive, predict the response, advance the model.
  task automatic cycle(input bit rst, input logic [31:0] a, input bit stl,
                       input bit exv, input logic [31:0] expc, input bit ext,
                       input logic [31:0] extgt, input bit expt,
                       input logic [31:0] exptgt);
    exp_t e;
    bit   mis;
    int   k;
    rst_n = rst; pc = a; stall = stl;
    ex_if.ex_valid = exv; ex_if.ex_pc = expc; ex_if.ex_taken = ext;
    ex_if.ex_target = extgt; ex_if.ex_pred_taken = expt;
    ex_if.ex_pred_target = exptgt;
    if (!rst) model_clear();
    mis = exv && ((ext != expt) || (ext && expt && extgt != exptgt));
    e.pt    = m_pred(a);
    e.ptgt  = m_ptgt(a);
    e.flush = mis;
    e.wren  = mis || !stl;
    e.cnt   = m_cnt;
    if (mis)           e.pc_next = ext ? extgt : expc + 32'd4;
    else if (stl)      e.pc_next = a + 32'd4;
    else if (e.pt)     e.pc_next = e.ptgt;
    else               e.pc_next = a + 32'd4;
    q.push_back(e);
    if (rst) begin
      if (exv) begin
        k = idx_of(expc);
        if (m_hit(expc)) begin
          if (ext) begin
            m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
            m_tgt[k] = extgt;
          end else begin
            m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
          end
        end else if (ext) begin
          m_valid[k] = 1; m_tag[k] = tag_of(expc); m_tgt[k] = extgt; m_ctr[k] = 2;
        end
      end
      if (mis) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a);
    cycle(1, a, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolve a branch with the prediction the model itself would have made.
  task automatic resolve(input logic [31:0] a, input logic [31:0] expc,
                         input bit ext, input logic [31:0] extgt);
    cycle(1, a, 0, 1, expc, ext, extgt, m_pred(expc), m_ptgt(expc));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("pc_next",     pc_next,     e.pc_next);
      chk("pc_wren",     32'(pc_wren), 32'(e.wren));
      chk("pred_taken",  32'(pred_taken), 32'(e.pt));
      chk("pred_target", pred_target, e.ptgt);
      chk("flush",       32'(flush),  32'(e.flush));
      chk("mispred_cnt", mispred_cnt, e.cnt);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h100 + 32'(4 * $urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a = a + 32'(4 * ENTRIES);
    return a;
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h200;
      1: return 32'h240;
      2: return 32'h300;
      default: return {$urandom(), 2'b00} >> 2 << 2;
    endcase
  endfunction

  initial begin
    int wait_cyc;
    logic [31:0] a, expc, extgt, exptgt;
    bit ext, expt;
    rst_n = 0; pc = 0; stall = 0;
    ex_if.ex_valid = 0; ex_if.ex_pc = 0; ex_if.ex_taken = 0;
    ex_if.ex_target = 0; ex_if.ex_pred_taken = 0; ex_if.ex_pred_target = 0;
    model_clear();
    @(posedge clk); #1;

    // Reset held, then sequential free-run.
    cycle(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 32'h4, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 16; i++) look(32'(4 * i));

    // Allocate on a taken mispredict, then hit.
    cycle(1, 32'h44, 0, 1, 32'h100, 1, 32'h200, 0, 32'h0);
    look(32'h100);

    // Counter hysteresis on that entry.
    resolve(32'h48, 32'h100, 0, 32'h0);
    look(32'h100);
    resolve(32'h4c, 32'h100, 1, 32'h200);
    look(32'h100);
    resolve(32'h50, 32'h100, 1, 32'h200);
    look(32'h100);
    for (int i = 0; i < 4; i++) resolve(32'h54, 32'h100, 0, 32'h0);
    look(32'h100);

    // Mispredict during stall, then plain stall.
    cycle(1, 32'h500, 1, 1, 32'h180, 1, 32'h300, 0, 32'h0);
    cycle(1, 32'h504, 1, 0, 0, 0, 0, 0, 0);

    // Same-cycle lookup and update: lookup sees the old entry.
    resolve(32'h100, 32'h100, 1, 32'h200);
    resolve(32'h100, 32'h100, 1, 32'h200);
    look(32'h100);

    // Target-only mispredict, then alias eviction.
    cycle(1, 32'h60, 0, 1, 32'h100, 1, 32'h240, 1, 32'h200);
    look(32'h100);
    cycle(1, 32'h64, 0, 1, 32'h100 + 4 * ENTRIES, 1, 32'h280, 0, 32'h0);
    look(32'h100);
    look(32'h100 + 4 * ENTRIES);

    // PC wrap, then reset asserted between edges with a populated table.
    look(32'hFFFF_FFFC);
    look(32'h180);
    cycle(0, 32'h180, 0, 0, 0, 0, 0, 0, 0);
    look(32'h180);
    look(32'h100 + 4 * ENTRIES);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      a    = rand_addr();
      expc = rand_addr();
      ext  = ($urandom_range(0, 2) != 0);
      extgt = ext ? rand_tgt() : 32'h0;
      if ($urandom_range(0, 1) == 0) begin
        expt = m_pred(expc); exptgt = m_ptgt(expc);
      end else begin
        expt = $urandom_range(0, 1) == 1; exptgt = rand_tgt();
      end
      cycle(($urandom_range(0, 99) != 0), a, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 6), expc, ext, extgt, expt, exptgt);
    end

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk); wait_cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
